// File: rtl/dmem_pkg.sv
// -----------------------------------------------------------------------------
// dmem_pkg
// Shared definitions for the parametrised data memory:
//   - dmem_state_t : access state machine encoding (IDLE, BUSY, DONE)
//   - DEF_*        : default parameter values
//   - byte_parity  : even-parity bit of one byte
// Optional feature macro used by the design: DMEM_PARITY_EN
// -----------------------------------------------------------------------------
package dmem_pkg;

  localparam int DEF_DATA_W  = 32;
  localparam int DEF_DEPTH   = 64;
  localparam int DEF_LATENCY = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } dmem_state_t;

  // Even parity: the stored bit makes the total count of ones even.
  function automatic logic byte_parity(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// -----------------------------------------------------------------------------
// dmem_array
// Word storage with one byte-enabled synchronous write port and one
// synchronous, registered read port.
// Ports:
//   clock     : rising-edge clock
//   reset     : asynchronous active-low reset (clears read register only;
//               the storage itself is never cleared)
//   we        : write strobe, bytes selected by byteen
//   re        : read strobe, rdata loads mem[addr] on the edge
//   addr      : word address
//   byteen    : per-byte write enables
//   wdata     : write data
//   rdata     : registered read data
//   perr      : registered parity mismatch of the last read
// Macro DMEM_PARITY_EN: when defined, one even-parity bit is kept per byte and
// checked on every read; otherwise perr is tied low.
// -----------------------------------------------------------------------------
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  we,
  input  logic                  re,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [DATA_W/8-1:0]   byteen,
  input  logic [DATA_W-1:0]     wdata,
  output logic [DATA_W-1:0]     rdata,
  output logic                  perr
);

  localparam int BE_W = DATA_W / 8;

  logic [DATA_W-1:0] mem [DEPTH];

  // Storage has no reset so it maps onto plain RAM.
  always_ff @(posedge clock) begin
    if (we) begin
      for (int i = 0; i < BE_W; i++) begin
        if (byteen[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)  rdata <= '0;
    else if (re) rdata <= mem[addr];
  end

`ifdef DMEM_PARITY_EN
  logic [BE_W-1:0] par_mem [DEPTH];
  logic [BE_W-1:0] mismatch;

  always_ff @(posedge clock) begin
    if (we) begin
      for (int i = 0; i < BE_W; i++) begin
        if (byteen[i]) par_mem[addr][i] <= byte_parity(wdata[8*i +: 8]);
      end
    end
  end

  always_comb begin
    mismatch = '0;
    for (int i = 0; i < BE_W; i++) begin
      mismatch[i] = byte_parity(mem[addr][8*i +: 8]) ^ par_mem[addr][i];
    end
  end

  // Registered alongside rdata and held until the next read.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)  perr <= 1'b0;
    else if (re) perr <= |mismatch;
  end
`else
  assign perr = 1'b0;
`endif

endmodule

// File: rtl/data_memory_param.sv
// -----------------------------------------------------------------------------
// data_memory_param
// Multi-cycle data memory for the load/store stage with a busywait handshake.
// Parameters: DATA_W (multiple of 8), DEPTH (power of two), ADDR_W (derived),
// LATENCY (>= 1 clock edges from acceptance to completion).
// Ports:
//   clock       : rising-edge clock
//   reset       : asynchronous active-low reset
//   read/write  : request lines, held by the requester until busywait falls
//   address     : word address
//   byteen      : write byte enables, bit i selects writedata[8i+7:8i]
//   writedata   : write data
//   readdata    : registered read data (updated only by read completions)
//   busywait    : stall to requester
//   parity_err  : parity mismatch on the last completed read
//   debug_state : current state of the access FSM
// Macro DMEM_PARITY_EN enables per-byte parity storage and checking.
//
// Handshake: in IDLE, a request is exactly one of read/write high; busywait
// rises combinationally in that same cycle and the request is latched on the
// next edge (E0). busywait stays high through BUSY and falls at edge
// E0+LATENCY when the access completes (DONE, one cycle). Requests are ignored
// in DONE, so a request still held there is seen again only once back in IDLE.
// read and write both high is illegal and ignored. Port values are only
// sampled at acceptance.
// -----------------------------------------------------------------------------
module data_memory_param
  import dmem_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int DEPTH   = DEF_DEPTH,
  parameter int ADDR_W  = $clog2(DEPTH),
  parameter int LATENCY = DEF_LATENCY
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  read,
  input  logic                  write,
  input  logic [ADDR_W-1:0]     address,
  input  logic [DATA_W/8-1:0]   byteen,
  input  logic [DATA_W-1:0]     writedata,
  output logic [DATA_W-1:0]     readdata,
  output logic                  busywait,
  output logic                  parity_err,
  output dmem_state_t           debug_state
);

  localparam int BE_W  = DATA_W / 8;
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  dmem_state_t          state_q, state_d;
  logic [CNT_W-1:0]     cnt_q;
  logic                 op_wr_q;
  logic [ADDR_W-1:0]    addr_q;
  logic [BE_W-1:0]      be_q;
  logic [DATA_W-1:0]    wd_q;

  logic                 accept;
  logic                 do_rd;
  logic                 do_wr;

  always_comb begin
    state_d  = state_q;
    busywait = 1'b0;
    accept   = 1'b0;
    do_rd    = 1'b0;
    do_wr    = 1'b0;
    case (state_q)
      IDLE: begin
        busywait = read ^ write;
        if (read ^ write) begin
          accept  = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        busywait = 1'b1;
        if (cnt_q == '0) begin
          do_rd   = ~op_wr_q;
          do_wr   = op_wr_q;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Resetting state discards any pending write: the array write strobe is
  // only raised from BUSY.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_wr_q <= 1'b0;
      addr_q  <= '0;
      be_q    <= '0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        cnt_q   <= CNT_W'(LATENCY - 1);
        op_wr_q <= write;
        addr_q  <= address;
        be_q    <= byteen;
        wd_q    <= writedata;
      end else if (state_q == BUSY && cnt_q != '0) begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

  dmem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_array (
    .clock  (clock),
    .reset  (reset),
    .we     (do_wr),
    .re     (do_rd),
    .addr   (addr_q),
    .byteen (be_q),
    .wdata  (wd_q),
    .rdata  (readdata),
    .perr   (parity_err)
  );

  assign debug_state = state_q;

endmodule

// File: tb/tb_data_memory_param.sv
// -----------------------------------------------------------------------------
// tb_data_memory_param
// Self-checking bench for data_memory_param: directed scenarios plus random
// accesses, checked against an array model and a completion scoreboard.
// -----------------------------------------------------------------------------
module tb_data_memory_param;
  import dmem_pkg::*;

  localparam int DATA_W  = 32;
  localparam int DEPTH   = 64;
  localparam int ADDR_W  = 6;
  localparam int LATENCY = 5;
  localparam int BE_W    = DATA_W / 8;

  // clock / reset
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  logic                read = 1'b0;
  logic                write = 1'b0;
  logic [ADDR_W-1:0]   address = '0;
  logic [BE_W-1:0]     byteen = '0;
  logic [DATA_W-1:0]   writedata = '0;
  logic [DATA_W-1:0]   readdata;
  logic                busywait;
  logic                parity_err;
  dmem_state_t         debug_state;

  data_memory_param #(
    .DATA_W  (DATA_W),
    .DEPTH   (DEPTH),
    .ADDR_W  (ADDR_W),
    .LATENCY (LATENCY)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .read        (read),
    .write       (write),
    .address     (address),
    .byteen      (byteen),
    .writedata   (writedata),
    .readdata    (readdata),
    .busywait    (busywait),
    .parity_err  (parity_err),
    .debug_state (debug_state)
  );

  // reference model and scoreboard
  logic [DATA_W-1:0] mem_model [DEPTH];
  logic [DATA_W-1:0] last_rd = '0;
  logic              last_perr = 1'b0;
  logic [DATA_W-1:0] exp_q[$];
  logic              perr_q[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Every completion (DONE cycle) consumes one expected readdata/parity pair.
  always @(negedge clock) begin
    logic [DATA_W-1:0] e;
    logic              p;
    if (reset && debug_state == DONE) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_completion: got a completion expected none at %0t", $time);
      end else begin
        e = exp_q.pop_front();
        p = perr_q.pop_front();
        chk("readdata", readdata, e);
        chk("parity_err", {31'b0, parity_err}, {31'b0, p});
      end
    end
  end

  // Driver: called on a falling edge while the DUT is idle. Returns on the
  // DONE falling edge if hold is set (request left asserted), else one cycle
  // later with the request removed.
  task automatic access(input bit is_wr, input logic [ADDR_W-1:0] a,
                        input logic [BE_W-1:0] be, input logic [DATA_W-1:0] d,
                        input bit hold, input bit scramble);
    int busy_cycles;
    bit done;
    if (is_wr) begin
      for (int i = 0; i < BE_W; i++)
        if (be[i]) mem_model[a][8*i +: 8] = d[8*i +: 8];
    end else begin
      last_rd   = mem_model[a];
      last_perr = 1'b0;
    end
    exp_q.push_back(last_rd);
    perr_q.push_back(last_perr);

    read = !is_wr; write = is_wr; address = a; byteen = be; writedata = d;
    #1;
    chk("busywait_comb", {31'b0, busywait}, 32'd1);
    busy_cycles = 1;
    done = 0;
    for (int k = 0; k < LATENCY + 20 && !done; k++) begin
      @(negedge clock);
      if (busywait) begin
        busy_cycles++;
        if (scramble) begin
          address   = ADDR_W'($urandom_range(DEPTH - 1, 0));
          writedata = $urandom;
          byteen    = BE_W'($urandom_range(15, 0));
        end
      end else begin
        done = 1;
      end
    end
    chk("access_done", {31'b0, done}, 32'd1);
    chk("busy_cycles", busy_cycles, LATENCY + 1);
    if (!hold) begin
      read = 1'b0; write = 1'b0;
      @(negedge clock);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // reset state
    #12;
    chk("reset_readdata", readdata, 32'h0);
    chk("reset_busywait", {31'b0, busywait}, 32'd0);
    chk("reset_parity", {31'b0, parity_err}, 32'd0);
    chk("reset_state", {30'b0, debug_state}, {30'b0, IDLE});
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);

    // preload every word so the model is fully defined
    for (int i = 0; i < DEPTH; i++) begin
      logic [DATA_W-1:0] v;
      v = $urandom;
      if (i == 9) v = 32'hCAFEF00D;
      access(1'b1, ADDR_W'(i), 4'hF, v, 1'b0, 1'b0);
    end

    // full-word write then read
    access(1'b1, 6'd3, 4'hF, 32'hDEADBEEF, 1'b0, 1'b0);
    access(1'b0, 6'd3, 4'h0, 32'h0, 1'b0, 1'b0);

    // partial byte-enable merge
    access(1'b1, 6'd7, 4'hF, 32'h11223344, 1'b0, 1'b0);
    access(1'b1, 6'd7, 4'b0101, 32'hAABBCCDD, 1'b0, 1'b0);
    access(1'b0, 6'd7, 4'h0, 32'h0, 1'b0, 1'b0);
    chk("merge_model", mem_model[7], 32'h11BB33DD);

    // byteen = 0: handshake still runs, memory unchanged
    access(1'b1, 6'd7, 4'h0, 32'hFFFFFFFF, 1'b0, 1'b0);
    access(1'b0, 6'd7, 4'h0, 32'h0, 1'b0, 1'b0);

    // illegal read+write: ignored
    read = 1'b1; write = 1'b1; address = 6'd3; byteen = 4'hF; writedata = 32'h0BADF00D;
    #1;
    chk("illegal_busywait", {31'b0, busywait}, 32'd0);
    repeat (3) @(negedge clock);
    chk("illegal_state", {30'b0, debug_state}, {30'b0, IDLE});
    chk("illegal_busywait_hold", {31'b0, busywait}, 32'd0);
    read = 1'b0; write = 1'b0;
    @(negedge clock);
    access(1'b0, 6'd3, 4'h0, 32'h0, 1'b0, 1'b0);

    // reset in the middle of a write
    access(1'b0, 6'd9, 4'h0, 32'h0, 1'b0, 1'b0);
    write = 1'b1; address = 6'd9; byteen = 4'hF; writedata = 32'h00000055;
    @(posedge clock);  // E0
    @(posedge clock);
    @(posedge clock);  // E0+2
    #1;
    reset = 1'b0; write = 1'b0;
    #1;
    chk("midreset_busywait", {31'b0, busywait}, 32'd0);
    chk("midreset_readdata", readdata, 32'h0);
    chk("midreset_state", {30'b0, debug_state}, {30'b0, IDLE});
    last_rd = '0;
    last_perr = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    access(1'b0, 6'd9, 4'h0, 32'h0, 1'b0, 1'b0);

    // read held across completion: one access per pass through IDLE
    access(1'b0, 6'd5, 4'h0, 32'h0, 1'b1, 1'b0);
    chk("hold_done_busywait", {31'b0, busywait}, 32'd0);
    @(negedge clock);
    chk("hold_back_idle", {30'b0, debug_state}, {30'b0, IDLE});
    chk("hold_reaccept_busywait", {31'b0, busywait}, 32'd1);
    access(1'b0, 6'd5, 4'h0, 32'h0, 1'b0, 1'b0);

`ifdef DMEM_PARITY_EN
    // corrupt one stored bit of word 2
    dut.u_array.mem[2][0] = ~dut.u_array.mem[2][0];
    mem_model[2][0] = ~mem_model[2][0];
    last_rd = mem_model[2];
    last_perr = 1'b1;
    exp_q.push_back(last_rd);
    perr_q.push_back(last_perr);
    read = 1'b1; address = 6'd2;
    for (int k = 0; k < LATENCY + 20 && (busywait || debug_state != DONE); k++)
      @(negedge clock);
    read = 1'b0;
    @(negedge clock);
    access(1'b0, 6'd4, 4'h0, 32'h0, 1'b0, 1'b0);
`endif

    // random traffic with port scrambling during BUSY
    for (int n = 0; n < 60; n++) begin
      access(1'($urandom_range(1, 0)), ADDR_W'($urandom_range(DEPTH - 1, 0)),
             BE_W'($urandom_range(15, 0)), $urandom, 1'b0, 1'b1);
      repeat ($urandom_range(2, 0)) @(negedge clock);
    end

    repeat (4) @(negedge clock);
    chk("scoreboard_empty", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
